// File: rtl/bird_game_pkg.sv
// Shared geometry, state encoding and hit-source codes for the bird game.
// Used by the collision scorer and its per-bar hit checker.
package bird_game_pkg;

    localparam logic [10:0] BAR_X0    = 11'd40;
    localparam logic [10:0] BAR_PITCH = 11'd80;
    localparam logic [10:0] BAR_W     = 11'd20;
    localparam logic [10:0] BIRD_SIZE = 11'd16;
    localparam logic [10:0] SCREEN_W  = 11'd640;
    localparam logic [10:0] SCREEN_H  = 11'd480;
    localparam logic [9:0]  MAX_LEVEL = 10'd15;
    localparam int          NUM_BARS  = 8;

    localparam logic [3:0] HIT_FLOOR = 4'd8;
    localparam logic [3:0] HIT_NONE  = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SCAN,
        DEAD
    } state_e;

    function automatic logic [10:0] bar_lx(logic [2:0] idx);
        return BAR_X0 + BAR_PITCH * {8'd0, idx};
    endfunction

    // bar0 lives in the top 10 bits of the packed bus
    function automatic logic [9:0] bar_field(logic [79:0] v, logic [2:0] idx);
        logic [9:0] r;
        r = '0;
        for (int k = 0; k < NUM_BARS; k++) begin
            if (idx == 3'(k)) r = v[79-10*k -: 10];
        end
        return r;
    endfunction

endpackage

// File: rtl/bar_hit_check.sv
// Combinational bird-versus-one-bar test: overlap, hit and cleared.
// A single instance is shared by all bars through the scan index mux.
module bar_hit_check
    import bird_game_pkg::*;
(
    input  logic [9:0]  pos_i,
    input  logic [9:0]  op_i,
    input  logic [10:0] lx_i,
    input  logic [9:0]  bird_x_i,
    input  logic [9:0]  bird_y_i,
    output logic        overlap_o,
    output logic        hit_o,
    output logic        cleared_o
);

    logic [10:0] bx;
    logic [10:0] by;
    logic [10:0] top;
    logic [10:0] bot;

    assign bx  = {1'b0, bird_x_i};
    assign by  = {1'b0, bird_y_i};
    assign top = {1'b0, pos_i};
    assign bot = top + {1'b0, op_i};

    assign overlap_o = (bx + BIRD_SIZE > lx_i) && (bx < lx_i + BAR_W);
    assign hit_o     = overlap_o && ((by < top) || (by + BIRD_SIZE > bot));
    assign cleared_o = bx >= lx_i + BAR_W;

endmodule

// File: rtl/bar_collision_scorer.sv
// Frame-ticked collision scan, scoring, level control and game-over state.
// Optional INVINCIBLE_EN adds an `invincible` input that suppresses DEAD.
module bar_collision_scorer
    import bird_game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        pause,
    input  logic        start,
    input  logic [9:0]  bird_x,
    input  logic [9:0]  bird_y,
    input  logic [79:0] bar_pos,
    input  logic [79:0] bar_op,
`ifdef INVINCIBLE_EN
    input  logic        invincible,
`endif
    output logic [9:0]  level,
    output logic [15:0] score,
    output logic        dead,
    output logic [3:0]  hit_src,
    output logic        level_up,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [9:0]  bx_q, bx_d;
    logic [9:0]  by_q, by_d;
    logic [79:0] pos_q, pos_d;
    logic [79:0] op_q, op_d;
    logic [7:0]  passed_q, passed_d;
    logic [15:0] score_q, score_d;
    logic [9:0]  level_q, level_d;
    logic [3:0]  hit_q, hit_d;
    logic        lvl_up_q, lvl_up_d;

    logic bar_ovl, bar_hit, bar_clr;
    logic floor_hit, any_hit, inv;

`ifdef INVINCIBLE_EN
    assign inv = invincible;
`else
    assign inv = 1'b0;
`endif

    bar_hit_check u_chk (
        .pos_i     (bar_field(pos_q, idx_q)),
        .op_i      (bar_field(op_q, idx_q)),
        .lx_i      (bar_lx(idx_q)),
        .bird_x_i  (bx_q),
        .bird_y_i  (by_q),
        .overlap_o (bar_ovl),
        .hit_o     (bar_hit),
        .cleared_o (bar_clr)
    );

    assign floor_hit = (idx_q == 3'd0) && ({1'b0, by_q} + BIRD_SIZE > SCREEN_H);
    assign any_hit   = floor_hit || (bar_ovl && bar_hit);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bx_d     = bx_q;
        by_d     = by_q;
        pos_d    = pos_q;
        op_d     = op_q;
        passed_d = passed_q;
        score_d  = score_q;
        level_d  = level_q;
        hit_d    = hit_q;
        lvl_up_d = 1'b0;
        unique case (state_q)
            IDLE, DEAD: begin
                if (start) begin
                    score_d  = '0;
                    passed_d = '0;
                    hit_d    = HIT_NONE;
                    level_d  = 10'd1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (frame_tick && !pause) begin
                    bx_d    = bird_x;
                    by_d    = bird_y;
                    pos_d   = bar_pos;
                    op_d    = bar_op;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (any_hit) hit_d = floor_hit ? HIT_FLOOR : {1'b0, idx_q};
                if (!any_hit && !passed_q[idx_q] && bar_clr) begin
                    passed_d[idx_q] = 1'b1;
                    if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                end
                if (any_hit && !inv) begin
                    state_d = DEAD;
                end else if (idx_q == 3'd7) begin
                    state_d = WAIT;
                    // final bar folds its own pass bit into the level-up test
                    if (!any_hit && passed_d == 8'hFF &&
                        {1'b0, bx_q} + BIRD_SIZE >= SCREEN_W) begin
                        if (level_q < MAX_LEVEL) level_d = level_q + 10'd1;
                        lvl_up_d = 1'b1;
                        passed_d = '0;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            pos_q    <= '0;
            op_q     <= '0;
            passed_q <= '0;
            score_q  <= '0;
            level_q  <= 10'd1;
            hit_q    <= HIT_NONE;
            lvl_up_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            pos_q    <= pos_d;
            op_q     <= op_d;
            passed_q <= passed_d;
            score_q  <= score_d;
            level_q  <= level_d;
            hit_q    <= hit_d;
            lvl_up_q <= lvl_up_d;
        end
    end

    assign level    = level_q;
    assign score    = score_q;
    assign hit_src  = hit_q;
    assign level_up = lvl_up_q;
    assign dead     = (state_q == DEAD);
    assign busy     = (state_q == SCAN);

endmodule

// File: tb/tb_bar_collision_scorer.sv
// Randomized and directed bench for bar_collision_scorer.
// Reference model evaluates each frame as a whole from the game rules.
module tb_bar_collision_scorer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        pause = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  bird_x = '0;
    logic [9:0]  bird_y = '0;
    logic [79:0] bar_pos = '0;
    logic [79:0] bar_op = '0;
    logic [9:0]  level;
    logic [15:0] score;
    logic        dead;
    logic [3:0]  hit_src;
    logic        level_up;
    logic        busy;

    bar_collision_scorer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .pause      (pause),
        .start      (start),
        .bird_x     (bird_x),
        .bird_y     (bird_y),
        .bar_pos    (bar_pos),
        .bar_op     (bar_op),
        .level      (level),
        .score      (score),
        .dead       (dead),
        .hit_src    (hit_src),
        .level_up   (level_up),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int lu_cnt = 0;

    always @(posedge clk) if (level_up) lu_cnt++;

    // model: run 0 = idle, 1 = playing, 2 = dead
    int       m_run = 0;
    int       m_score = 0;
    int       m_level = 1;
    int       m_hit = 15;
    int       m_dead = 0;
    bit [7:0] m_passed = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_score = 0; m_level = 1; m_hit = 15; m_dead = 0; m_passed = '0;
    endtask

    task automatic model_start();
        if (m_run != 1) begin
            m_run = 1; m_score = 0; m_level = 1; m_hit = 15; m_dead = 0; m_passed = '0;
        end
    endtask

    task automatic model_scan(input int bx, input int by, input logic [79:0] pos,
                              input logic [79:0] op, output int len, output int lu);
        int lx, p, o;
        len = 0;
        lu = 0;
        if (m_run != 1) return;
        for (int i = 0; i < 8; i++) begin
            len = i + 1;
            if (i == 0 && by + 16 > 480) begin
                m_hit = 8; m_dead = 1; m_run = 2;
                return;
            end
            lx = 40 + 80 * i;
            p = int'(pos[79-10*i -: 10]);
            o = int'(op[79-10*i -: 10]);
            if (bx + 16 > lx && bx < lx + 20 && (by < p || by + 16 > p + o)) begin
                m_hit = i; m_dead = 1; m_run = 2;
                return;
            end
            if (!m_passed[i] && bx >= lx + 20) begin
                m_passed[i] = 1'b1;
                if (m_score < 65535) m_score++;
            end
        end
        if (m_passed == 8'hFF && bx + 16 >= 640) begin
            if (m_level < 15) m_level++;
            lu = 1;
            m_passed = '0;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".score"}, 32'(score), 32'(m_score));
        chk({tag, ".level"}, 32'(level), 32'(m_level));
        chk({tag, ".hit"}, 32'(hit_src), 32'(m_hit));
        chk({tag, ".dead"}, 32'(dead), 32'(m_dead));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        model_start();
        check_state("start");
    endtask

    function automatic logic [79:0] rnd80();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    task automatic do_tick(input string tag, input bit p, input int bx, input int by,
                           input logic [79:0] pos, input logic [79:0] op);
        int len, lu, lu_base, prior_dead;
        prior_dead = m_dead;
        bird_x = 10'(bx); bird_y = 10'(by); bar_pos = pos; bar_op = op; pause = p;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        lu_base = lu_cnt;
        // scramble live inputs; the scan must use its snapshot
        bird_x = 10'($urandom()); bird_y = 10'($urandom());
        bar_pos = rnd80(); bar_op = rnd80();
        if (p) len = 0;
        else model_scan(bx, by, pos, op, len, lu);
        if (p) lu = 0;
        for (int j = 1; j <= 10; j++) begin
            if (j > 1) @(negedge clk);
            chk({tag, ".busy_t"}, 32'(busy), 32'(j <= len));
            chk({tag, ".dead_t"}, 32'(dead), 32'((j > len) ? m_dead : prior_dead));
        end
        chk({tag, ".lvlup"}, 32'(lu_cnt - lu_base), 32'(lu));
        check_state(tag);
    endtask

    logic [79:0] open_pos, open_op, b0_pos, b0_op;

    initial begin
        for (int i = 0; i < 8; i++) begin
            open_pos[79-10*i -: 10] = 10'd0;
            open_op[79-10*i -: 10]  = 10'd480;
        end
        b0_pos = open_pos; b0_op = open_op;
        b0_pos[79:70] = 10'd120; b0_op[79:70] = 10'd60;

        #12;
        check_state("reset");
        chk("reset.lvlup", 32'(level_up), 32'd0);
        rst_n = 1'b1;

        do_tick("idle_tick", 1'b0, 45, 130, b0_pos, b0_op);
        do_start();
        do_tick("safe", 1'b0, 45, 130, b0_pos, b0_op);
        do_tick("barhit", 1'b0, 45, 110, b0_pos, b0_op);
        do_tick("dead_tick", 1'b0, 45, 130, b0_pos, b0_op);
        do_start();
        do_tick("score1", 1'b0, 70, 130, open_pos, open_op);
        do_tick("score2", 1'b0, 70, 130, open_pos, open_op);
        do_start();
        for (int k = 0; k < 16; k++) do_tick("lvl", 1'b0, 624, 100, open_pos, open_op);
        do_tick("floor_p", 1'b1, 300, 470, open_pos, open_op);
        do_tick("floor", 1'b0, 300, 470, open_pos, open_op);
        do_start();

        // reset while scanning bar 3
        bird_x = 10'd45; bird_y = 10'd130; bar_pos = b0_pos; bar_op = b0_op;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid.busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("midrst");
        @(negedge clk) rst_n = 1'b1;
        do_tick("after_rst", 1'b0, 45, 130, b0_pos, b0_op);
        do_start();

        for (int r = 0; r < 60; r++) begin
            logic [79:0] rp, ro;
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    rp[79-10*i -: 10] = 10'd0;
                    ro[79-10*i -: 10] = 10'd1000;
                end else begin
                    rp[79-10*i -: 10] = 10'($urandom_range(0, 400));
                    ro[79-10*i -: 10] = 10'($urandom_range(16, 480));
                end
            end
            if ($urandom_range(0, 9) == 0) do_start();
            else do_tick("rnd", $urandom_range(0, 4) == 0,
                         int'($urandom_range(0, 630)), int'($urandom_range(0, 470)), rp, ro);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
